// File: rtl/pfb_pkg.sv
// ---------------------------------------------------------------------------
// pfb_pkg
// Shared definitions for the PFB channelizer circular-shift buffer front end:
// datapath widths, the sequencer state encoding and the FFT-size legality
// check (power of two between a minimum and 512).
// ---------------------------------------------------------------------------
package pfb_pkg;

  localparam int FFT_SIZE_W = 10;
  localparam int PHASE_W    = 9;
  localparam int SAMPLE_W   = 36;
  localparam int unsigned MAX_FFT_SIZE = 32'd512;

  // Sequencer states: running, config pending (finishing the frame), draining.
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_DRAIN = 2'd2
  } seq_state_t;

  // True when size is a power of two inside [min_size, MAX_FFT_SIZE].
  function automatic logic is_legal_fft_size(
    input logic [FFT_SIZE_W-1:0] size,
    input int unsigned           min_size
  );
    logic [FFT_SIZE_W-1:0] size_m1;
    logic [31:0]           size_ext;
    size_m1  = size - 10'd1;
    size_ext = {22'd0, size};
    return (size != 10'd0) &&
           ((size & size_m1) == 10'd0) &&
           (size_ext >= min_size) &&
           (size_ext <= MAX_FFT_SIZE);
  endfunction

endpackage

// File: rtl/circ_buffer_drain_timer.sv
// ---------------------------------------------------------------------------
// circ_buffer_drain_timer
// Loadable down-counter timing the buffer drain. A load sets the count to
// load_val; while enabled the count decrements towards zero. done is a
// registered flag that is high while the count equals 1, i.e. in the last
// cycle of the drain window, so a window loaded with N lasts exactly N
// enabled cycles. load has priority over counting.
//
// Ports:
//   clk        in   clock
//   sync_reset in   asynchronous active-high reset
//   load       in   load count with load_val
//   load_val   in   CNT_W-bit drain length
//   enable     in   count down this cycle
//   done       out  last cycle of the drain window
// ---------------------------------------------------------------------------
module circ_buffer_drain_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Count register and its registered "count == 1" flag.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      count_r <= {CNT_W{1'b0}};
      done    <= 1'b0;
    end else if (load) begin
      count_r <= load_val;
      done    <= (load_val == CNT_W'(1));
    end else if (enable && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
      done    <= (count_r == CNT_W'(2));
    end else begin
      count_r <= count_r;
      done    <= done;
    end
  end

endmodule

// File: rtl/circ_buffer_seq.sv
// ---------------------------------------------------------------------------
// circ_buffer_seq
// Input sequencer and configuration controller for the circular-shift buffer
// of the PFB channelizer. Accepts the AXI-Stream sample flow from the
// polyphase filter and produces the buffer write phase, data, strobe and the
// active FFT size. Size changes take effect only at a frame boundary, after
// which input is stalled for one old frame plus DRAIN_PAD cycles so the
// ping-pong memories never mix frames of two sizes.
//
// Ports:
//   clk, sync_reset          clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready  sample stream (tlast only checked)
//   cfg_fft_size, cfg_valid  requested FFT size and its one-cycle strobe
//   buf_phase, buf_data, buf_valid    registered write to the buffer
//   buf_fft_size             active FFT size
//   busy                     config pending or draining
//   cfg_err                  one-cycle pulse on a rejected config
//   align_err                sticky tlast misalignment flag
// ---------------------------------------------------------------------------
module circ_buffer_seq
  import pfb_pkg::*;
#(
  parameter int unsigned DEFAULT_FFT_SIZE = 256,
  parameter int unsigned DRAIN_PAD        = 12,
  parameter int unsigned MIN_FFT_SIZE     = 8
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic [SAMPLE_W-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [FFT_SIZE_W-1:0] cfg_fft_size,
  input  logic                  cfg_valid,
  output logic [PHASE_W-1:0]    buf_phase,
  output logic [SAMPLE_W-1:0]   buf_data,
  output logic                  buf_valid,
  output logic [FFT_SIZE_W-1:0] buf_fft_size,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  align_err
);

  localparam int DRAIN_W = 11;

  seq_state_t            state_r;
  logic [PHASE_W-1:0]    phase_cnt_r;
  logic [FFT_SIZE_W-1:0] pend_size_r;

  logic                  accept_s;
  logic [PHASE_W-1:0]    last_idx_s;
  logic                  at_last_s;
  logic                  cfg_legal_s;
  logic                  cfg_illegal_s;
  logic                  cfg_new_s;
  logic                  drain_load_s;
  logic                  drain_en_s;
  logic                  drain_done_s;
  logic [FFT_SIZE_W-1:0] next_size_s;
  logic [DRAIN_W-1:0]    drain_len_s;

  // Ready depends on registered state only: stalled while draining.
  assign s_axis_tready = (state_r != S_DRAIN);
  assign accept_s      = s_axis_tvalid & s_axis_tready;

  // Last phase of a frame; 512-1 still fits the 9-bit phase counter.
  assign last_idx_s    = PHASE_W'(buf_fft_size - 10'd1);
  assign at_last_s     = (phase_cnt_r == last_idx_s);

  assign cfg_legal_s   = cfg_valid & is_legal_fft_size(cfg_fft_size, MIN_FFT_SIZE);
  assign cfg_illegal_s = cfg_valid & ~cfg_legal_s;
  // Only a genuinely different size starts a change from the idle state.
  assign cfg_new_s     = cfg_legal_s & (cfg_fft_size != buf_fft_size);

  // Drain covers one frame of the size still held in the buffer plus pad.
  assign drain_len_s   = {1'b0, buf_fft_size} + DRAIN_W'(DRAIN_PAD);
  assign drain_en_s    = (state_r == S_DRAIN);

  // Decide when to (re)start the drain window and which size it installs.
  always_comb begin
    drain_load_s = 1'b0;
    next_size_s  = buf_fft_size;
    case (state_r)
      S_RUN: begin
        if (cfg_new_s && (phase_cnt_r == {PHASE_W{1'b0}})) begin
          drain_load_s = 1'b1;
          next_size_s  = cfg_fft_size;
        end else begin
          drain_load_s = 1'b0;
          next_size_s  = buf_fft_size;
        end
      end
      S_PEND: begin
        if (accept_s && at_last_s) begin
          drain_load_s = 1'b1;
          // A config landing on the frame's final accept still counts.
          next_size_s  = cfg_legal_s ? cfg_fft_size : pend_size_r;
        end else begin
          drain_load_s = 1'b0;
          next_size_s  = buf_fft_size;
        end
      end
      S_DRAIN: begin
        if (cfg_legal_s) begin
          drain_load_s = 1'b1;
          next_size_s  = cfg_fft_size;
        end else begin
          drain_load_s = 1'b0;
          next_size_s  = buf_fft_size;
        end
      end
      default: begin
        drain_load_s = 1'b0;
        next_size_s  = buf_fft_size;
      end
    endcase
  end

  circ_buffer_drain_timer #(
    .CNT_W (DRAIN_W)
  ) u_drain_timer (
    .clk        (clk),
    .sync_reset (sync_reset),
    .load       (drain_load_s),
    .load_val   (drain_len_s),
    .enable     (drain_en_s),
    .done       (drain_done_s)
  );

  // Sequencer FSM with registered buffer-side outputs.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_r      <= S_RUN;
      phase_cnt_r  <= {PHASE_W{1'b0}};
      pend_size_r  <= FFT_SIZE_W'(DEFAULT_FFT_SIZE);
      buf_phase    <= {PHASE_W{1'b0}};
      buf_data     <= {SAMPLE_W{1'b0}};
      buf_valid    <= 1'b0;
      buf_fft_size <= FFT_SIZE_W'(DEFAULT_FFT_SIZE);
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      cfg_err   <= cfg_illegal_s;
      buf_valid <= accept_s;

      if (accept_s) begin
        buf_data    <= s_axis_tdata;
        buf_phase   <= phase_cnt_r;
        phase_cnt_r <= at_last_s ? {PHASE_W{1'b0}} : (phase_cnt_r + 9'd1);
        // tlast is only monitored; it never steers the phase.
        if (s_axis_tlast != at_last_s) begin
          align_err <= 1'b1;
        end
      end

      case (state_r)
        S_RUN: begin
          if (cfg_new_s) begin
            busy         <= 1'b1;
            pend_size_r  <= cfg_fft_size;
            buf_fft_size <= next_size_s;
            state_r      <= drain_load_s ? S_DRAIN : S_PEND;
          end
        end
        S_PEND: begin
          if (cfg_legal_s) begin
            pend_size_r <= cfg_fft_size;
          end
          if (drain_load_s) begin
            buf_fft_size <= next_size_s;
            state_r      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cfg_legal_s) begin
            // Late config: apply now and restart the full drain window.
            pend_size_r  <= cfg_fft_size;
            buf_fft_size <= next_size_s;
          end else if (drain_done_s) begin
            busy        <= 1'b0;
            phase_cnt_r <= {PHASE_W{1'b0}};
            state_r     <= S_RUN;
          end
        end
        default: begin
          state_r <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circ_buffer_seq.sv
// ---------------------------------------------------------------------------
// tb_circ_buffer_seq
// Self-checking bench for circ_buffer_seq: directed scenarios followed by a
// randomized phase, all compared cycle by cycle with a behavioural model.
// ---------------------------------------------------------------------------
module tb_circ_buffer_seq;

  localparam int DEF_SIZE = 256;
  localparam int PAD      = 12;
  localparam int MIN_SIZE = 8;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [35:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [9:0]  cfg_fft_size;
  logic        cfg_valid;
  logic [8:0]  buf_phase;
  logic [35:0] buf_data;
  logic        buf_valid;
  logic [9:0]  buf_fft_size;
  logic        busy;
  logic        cfg_err;
  logic        align_err;

  always #5 clk = ~clk;

  circ_buffer_seq #(
    .DEFAULT_FFT_SIZE (DEF_SIZE),
    .DRAIN_PAD        (PAD),
    .MIN_FFT_SIZE     (MIN_SIZE)
  ) dut (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .cfg_fft_size  (cfg_fft_size),
    .cfg_valid     (cfg_valid),
    .buf_phase     (buf_phase),
    .buf_data      (buf_data),
    .buf_valid     (buf_valid),
    .buf_fft_size  (buf_fft_size),
    .busy          (busy),
    .cfg_err       (cfg_err),
    .align_err     (align_err)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int low_run = 0;

  // Reference model state.
  int          m_size, m_cnt, m_pend_size, m_drain, m_phase;
  bit          m_busy, m_align, m_valid, m_err;
  logic [35:0] m_data;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit size_ok(input int s);
    bit ok = 1'b0;
    for (int p = MIN_SIZE; p <= 512; p = p * 2)
      if (s == p) ok = 1'b1;
    return ok;
  endfunction

  task automatic model_reset();
    m_size = DEF_SIZE; m_cnt = 0; m_pend_size = DEF_SIZE; m_drain = 0;
    m_phase = 0; m_busy = 0; m_align = 0; m_valid = 0; m_err = 0; m_data = '0;
  endtask

  // One clock edge of the reference behaviour; m_drain>0 means draining,
  // with m_drain cycles of stall still to go.
  task automatic model_step(input bit tv, input logic [35:0] td, input bit tl,
                            input bit cv, input int cs);
    bit acc, last, at_zero, legal;
    acc     = tv && (m_drain == 0);
    last    = (m_cnt == m_size - 1);
    at_zero = (m_cnt == 0);
    legal   = cv && size_ok(cs);
    m_err   = cv && !legal;
    m_valid = acc;
    if (acc) begin
      m_phase = m_cnt;
      m_data  = td;
      if (tl != last) m_align = 1;
      m_cnt = last ? 0 : m_cnt + 1;
    end
    if (m_drain > 0) begin
      if (legal) begin
        m_drain = m_size + PAD;
        m_size  = cs;
      end else if (m_drain == 1) begin
        m_drain = 0; m_busy = 0; m_cnt = 0;
      end else begin
        m_drain--;
      end
    end else if (m_busy) begin
      if (legal) m_pend_size = cs;
      if (acc && last) begin
        m_drain = m_size + PAD;
        m_size  = m_pend_size;
      end
    end else if (legal && cs != m_size) begin
      m_busy = 1; m_pend_size = cs;
      if (at_zero) begin
        m_drain = m_size + PAD;
        m_size  = cs;
      end
    end
  endtask

  task automatic compare_all();
    check_val("buf_valid", buf_valid, m_valid);
    check_val("buf_phase", buf_phase, m_phase);
    check_val("buf_data", buf_data, m_data);
    check_val("buf_fft_size", buf_fft_size, m_size);
    check_val("busy", busy, m_busy);
    check_val("cfg_err", cfg_err, m_err);
    check_val("align_err", align_err, m_align);
    check_val("tready", s_axis_tready, (m_drain == 0));
  endtask

  // Drive one cycle of inputs (from a negedge), step the model at the edge
  // and compare on the following negedge.
  task automatic cycle(input bit tv, input bit tl, input bit cv, input int cs);
    logic [35:0] td;
    td = 36'({$urandom(), $urandom()});
    s_axis_tvalid = tv; s_axis_tdata = td; s_axis_tlast = tl;
    cfg_valid = cv; cfg_fft_size = 10'(cs);
    @(posedge clk);
    model_step(tv, td, tl, cv, cs);
    @(negedge clk);
    if (!s_axis_tready) low_run++;
    compare_all();
  endtask

  function automatic bit good_tlast();
    return (m_cnt == m_size - 1);
  endfunction

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, good_tlast(), 1'b0, 0);
  endtask

  task automatic stream_to(input int target, input string tag);
    for (int i = 0; i < 1200 && m_cnt != target; i++) cycle(1'b1, good_tlast(), 1'b0, 0);
    check_val(tag, buf_phase, 9'(target - 1));
  endtask

  task automatic stream_until_idle(input string tag);
    int i;
    for (i = 0; i < 3000 && (m_busy || m_drain != 0); i++) cycle(1'b1, good_tlast(), 1'b0, 0);
    check_val(tag, busy, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    s_axis_tvalid = 1'b0; cfg_valid = 1'b0;
    sync_reset = 1'b1;
    #1;
    check_val({tag, "_phase"}, buf_phase, 9'd0);
    check_val({tag, "_data"}, buf_data, 36'd0);
    check_val({tag, "_valid"}, buf_valid, 1'b0);
    check_val({tag, "_size"}, buf_fft_size, 10'd256);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_cfg_err"}, cfg_err, 1'b0);
    check_val({tag, "_align"}, align_err, 1'b0);
    check_val({tag, "_tready"}, s_axis_tready, 1'b1);
    model_reset();
    @(negedge clk);
    sync_reset = 1'b0;
  endtask

  initial begin
    sync_reset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    cfg_valid = 1'b0; cfg_fft_size = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    apply_reset("rst0");

    // Continuous stream at the default size: phases 0..255,0..255,0..87.
    stream(600);
    check_val("t2_last_phase", buf_phase, 9'd87);

    // Two illegal configs: error pulses, nothing else changes.
    cycle(1'b1, good_tlast(), 1'b1, 100);
    check_val("t4_err_a", cfg_err, 1'b1);
    cycle(1'b1, good_tlast(), 1'b0, 0);
    check_val("t4_err_a_clr", cfg_err, 1'b0);
    cycle(1'b1, good_tlast(), 1'b1, 4);
    check_val("t4_err_b", cfg_err, 1'b1);
    check_val("t4_size", buf_fft_size, 10'd256);
    check_val("t4_busy", busy, 1'b0);

    // Misplaced tlast at phase 10: sticky error, sequencing unaffected.
    stream_to(10, "t6_reach");
    cycle(1'b1, 1'b1, 1'b0, 0);
    check_val("t6_align", align_err, 1'b1);
    check_val("t6_phase10", buf_phase, 9'd10);
    cycle(1'b1, good_tlast(), 1'b0, 0);
    check_val("t6_phase11", buf_phase, 9'd11);
    check_val("t6_sticky", align_err, 1'b1);

    // Size 64 requested mid-frame: finish frame, 268-cycle stall, then 64.
    stream_to(100, "t3_reach");
    cycle(1'b1, good_tlast(), 1'b1, 64);
    check_val("t3_busy", busy, 1'b1);
    low_run = 0;
    stream_until_idle("t3_idle");
    check_val("t3_drain_len", low_run, 268);
    check_val("t3_size", buf_fft_size, 10'd64);
    stream(130);

    // Two configs while pending: single drain, last one wins.
    apply_reset("rst1");
    stream_to(50, "t5_reach");
    cycle(1'b1, good_tlast(), 1'b1, 128);
    stream(9);
    cycle(1'b1, good_tlast(), 1'b1, 32);
    low_run = 0;
    stream_until_idle("t5_idle");
    check_val("t5_drain_len", low_run, 268);
    check_val("t5_size", buf_fft_size, 10'd32);

    // Reset in the middle of a drain.
    stream_to(5, "t7_reach");
    cycle(1'b1, good_tlast(), 1'b1, 512);
    for (int i = 0; i < 3000 && m_drain == 0; i++) cycle(1'b1, good_tlast(), 1'b0, 0);
    stream(20);
    check_val("t7_in_drain", s_axis_tready, 1'b0);
    apply_reset("rst2");
    cycle(1'b1, good_tlast(), 1'b0, 0);
    check_val("t7_first_phase", buf_phase, 9'd0);
    check_val("t7_first_valid", buf_valid, 1'b1);

    // Randomized traffic, configs and occasional tlast errors.
    apply_reset("rst3");
    for (int i = 0; i < 4000; i++) begin
      bit tv, tl, cv;
      int cs, k;
      tv = ($urandom_range(0, 3) != 0);
      tl = good_tlast();
      if ($urandom_range(0, 199) == 0) tl = ~tl;
      cv = ($urandom_range(0, 149) == 0);
      k  = $urandom_range(0, 11);
      cs = (k < 9) ? (1 << (k + 2)) : $urandom_range(0, 1023);
      cs = cs & 1023;
      cycle(tv, tl, cv, cs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
